// File: rtl/uoram_backend_responder.sv
// Flat-RAM stand-in for the Path ORAM backend: serves one command at a time.
// Optional leaf tag storage and checking: define UORAM_BE_LEAFCHECK_EN.
module uoram_backend_responder #(
    parameter int FEDWidth  = 64,
    parameter int ORAMB     = 512,
    parameter int ORAMU     = 32,
    parameter int ORAML     = 10,
    parameter int NumBlocks = 256
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic                CmdOutReady,
    input  logic                CmdOutValid,
    input  logic [1:0]          CmdOut,
    input  logic [ORAMU-1:0]    AddrOut,
    input  logic [ORAML-1:0]    OldLeaf,
    input  logic [ORAML-1:0]    NewLeaf,
    output logic                StoreDataReady,
    input  logic                StoreDataValid,
    input  logic [FEDWidth-1:0] StoreData,
    input  logic                LoadDataReady,
    output logic                LoadDataValid,
    output logic [FEDWidth-1:0] LoadData,
    output logic                AddrError,
    output logic                LeafError
);
    localparam int BlkChunks = ORAMB / FEDWidth;
    localparam int AddrW     = (NumBlocks > 1) ? $clog2(NumBlocks) : 1;
    localparam int CntW      = (BlkChunks > 1) ? $clog2(BlkChunks) : 1;
    localparam int RamDepth  = NumBlocks * BlkChunks;
    localparam int RamAW     = (RamDepth > 1) ? $clog2(RamDepth) : 1;

    localparam logic [1:0] CmdUpdate  = 2'd0;
    localparam logic [1:0] CmdAppend  = 2'd1;
    localparam logic [1:0] CmdRead    = 2'd2;
    localparam logic [1:0] CmdReadRmv = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StStore,
        StLoad
    } stateT;

    stateT               state;
    stateT               nextState;
    logic                alive;
    logic [CntW-1:0]     cnt;
    logic [AddrW-1:0]    addrQ;
    logic [1:0]          cmdQ;
    logic                oobQ;
    logic                zeroQ;
    logic [NumBlocks-1:0] validBits;

    logic [FEDWidth-1:0] dataRam [RamDepth];

    logic                cmdFire;
    logic                storeFire;
    logic                loadFire;
    logic                lastCnt;
    logic [AddrW-1:0]    addrIn;
    logic                oobIn;
    logic                zeroIn;
    logic [RamAW-1:0]    wrIdx;
    logic [RamAW-1:0]    rdIdx;

    function automatic logic [RamAW-1:0] ramIdx(
        input logic [AddrW-1:0] a,
        input logic [CntW-1:0]  c
    );
        return RamAW'(a) * RamAW'(BlkChunks) + RamAW'(c);
    endfunction

    assign cmdFire   = CmdOutValid && CmdOutReady;
    assign storeFire = (state == StStore) && StoreDataValid;
    assign loadFire  = (state == StLoad) && LoadDataValid && LoadDataReady;
    assign lastCnt   = (cnt == CntW'(BlkChunks - 1));
    assign addrIn    = AddrOut[AddrW-1:0];
    assign oobIn     = (AddrOut >= ORAMU'(NumBlocks));
    assign zeroIn    = oobIn || !validBits[addrIn];
    assign wrIdx     = ramIdx(addrQ, cnt);
    // Idle reads chunk 0 of the incoming block; Load prefetches the next chunk.
    assign rdIdx     = (state == StIdle) ? ramIdx(addrIn, '0)
                                         : ramIdx(addrQ, cnt + 1'b1);

    always_comb begin
        nextState      = state;
        CmdOutReady    = 1'b0;
        StoreDataReady = 1'b0;
        unique case (state)
            StIdle: begin
                CmdOutReady = alive;
                if (cmdFire) begin
                    nextState = CmdOut[1] ? StLoad : StStore;
                end
            end
            StStore: begin
                StoreDataReady = 1'b1;
                if (storeFire && lastCnt) begin
                    nextState = StIdle;
                end
            end
            StLoad: begin
                if (loadFire && lastCnt) begin
                    nextState = StIdle;
                end
            end
            default: nextState = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= StIdle;
            alive         <= 1'b0;
            cnt           <= '0;
            addrQ         <= '0;
            cmdQ          <= CmdUpdate;
            oobQ          <= 1'b0;
            zeroQ         <= 1'b0;
            validBits     <= '0;
            LoadDataValid <= 1'b0;
            LoadData      <= '0;
            AddrError     <= 1'b0;
        end else begin
            state <= nextState;
            alive <= 1'b1;
            if (cmdFire) begin
                addrQ <= addrIn;
                cmdQ  <= CmdOut;
                oobQ  <= oobIn;
                cnt   <= '0;
                if (oobIn) begin
                    AddrError <= 1'b1;
                end
                if (CmdOut[1]) begin
                    zeroQ         <= zeroIn;
                    LoadDataValid <= 1'b1;
                    LoadData      <= zeroIn ? '0 : dataRam[rdIdx];
                end
            end
            if (storeFire) begin
                cnt <= lastCnt ? '0 : cnt + 1'b1;
                if (lastCnt && !oobQ) begin
                    validBits[addrQ] <= 1'b1;
                end
            end
            if (loadFire) begin
                if (lastCnt) begin
                    cnt           <= '0;
                    LoadDataValid <= 1'b0;
                    LoadData      <= '0;
                    if (!oobQ && cmdQ == CmdReadRmv) begin
                        validBits[addrQ] <= 1'b0;
                    end
                end else begin
                    cnt      <= cnt + 1'b1;
                    LoadData <= zeroQ ? '0 : dataRam[rdIdx];
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (storeFire && !oobQ) begin
            dataRam[wrIdx] <= StoreData;
        end
    end

`ifdef UORAM_BE_LEAFCHECK_EN
    logic [ORAML-1:0] tagRam [NumBlocks];
    logic [ORAML-1:0] newLeafQ;
    logic             tagWr;
    logic             leafMiss;

    assign tagWr = !oobQ && lastCnt &&
                   (storeFire || (loadFire && cmdQ == CmdRead));
    assign leafMiss = cmdFire && (CmdOut != CmdAppend) && !oobIn &&
                      validBits[addrIn] && (tagRam[addrIn] != OldLeaf);

    always_ff @(posedge Clock) begin
        if (tagWr) begin
            tagRam[addrQ] <= newLeafQ;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            newLeafQ  <= '0;
            LeafError <= 1'b0;
        end else begin
            if (cmdFire) begin
                newLeafQ <= NewLeaf;
            end
            if (leafMiss) begin
                LeafError <= 1'b1;
            end
        end
    end
`else
    logic unusedLeaf;
    assign unusedLeaf = ^{OldLeaf, NewLeaf};
    assign LeafError  = 1'b0;
`endif

endmodule

// File: tb/tb_uoram_backend_responder.sv
// Directed bench for uoram_backend_responder with default parameters.
// Expected LeafError follows UORAM_BE_LEAFCHECK_EN.
module tb_uoram_backend_responder;
    localparam int FEDWidth  = 64;
    localparam int ORAMU     = 32;
    localparam int ORAML     = 10;
    localparam int BlkChunks = 8;

    localparam logic [1:0] CmdUpdate  = 2'd0;
    localparam logic [1:0] CmdAppend  = 2'd1;
    localparam logic [1:0] CmdRead    = 2'd2;
    localparam logic [1:0] CmdReadRmv = 2'd3;

`ifdef UORAM_BE_LEAFCHECK_EN
    localparam logic LeafOn = 1'b1;
`else
    localparam logic LeafOn = 1'b0;
`endif

    logic                Clock;
    logic                Reset;
    logic                CmdOutReady;
    logic                CmdOutValid;
    logic [1:0]          CmdOut;
    logic [ORAMU-1:0]    AddrOut;
    logic [ORAML-1:0]    OldLeaf;
    logic [ORAML-1:0]    NewLeaf;
    logic                StoreDataReady;
    logic                StoreDataValid;
    logic [FEDWidth-1:0] StoreData;
    logic                LoadDataReady;
    logic                LoadDataValid;
    logic [FEDWidth-1:0] LoadData;
    logic                AddrError;
    logic                LeafError;

    int vectors = 0;
    int miscompares = 0;

    uoram_backend_responder dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .CmdOutReady    (CmdOutReady),
        .CmdOutValid    (CmdOutValid),
        .CmdOut         (CmdOut),
        .AddrOut        (AddrOut),
        .OldLeaf        (OldLeaf),
        .NewLeaf        (NewLeaf),
        .StoreDataReady (StoreDataReady),
        .StoreDataValid (StoreDataValid),
        .StoreData      (StoreData),
        .LoadDataReady  (LoadDataReady),
        .LoadDataValid  (LoadDataValid),
        .LoadData       (LoadData),
        .AddrError      (AddrError),
        .LeafError      (LeafError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic sendCmd(input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [9:0] oldL, input logic [9:0] newL);
        int n;
        CmdOut      = cmd;
        AddrOut     = addr;
        OldLeaf     = oldL;
        NewLeaf     = newL;
        CmdOutValid = 1'b1;
        n = 0;
        while (!CmdOutReady && n < 50) begin
            step();
            n++;
        end
        if (!CmdOutReady) check("cmd_timeout", 64'(CmdOutReady), 64'd1);
        step();
        CmdOutValid = 1'b0;
    endtask

    task automatic storeBlock(input logic [63:0] base, input int nChunks);
        StoreDataValid = 1'b1;
        for (int i = 0; i < nChunks; i++) begin
            StoreData = base + 64'(i);
            check("store_ready", 64'(StoreDataReady), 64'd1);
            step();
        end
        StoreDataValid = 1'b0;
    endtask

    // stallAt: chunk index held for two cycles with LoadDataReady low
    task automatic recvBlock(input string tag, input logic [63:0] base,
                             input bit zero, input int stallAt);
        logic [63:0] exp;
        LoadDataReady = 1'b1;
        for (int i = 0; i < BlkChunks; i++) begin
            exp = zero ? 64'd0 : base + 64'(i);
            if (i == stallAt) begin
                LoadDataReady = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    check({tag, "_hold_valid"}, 64'(LoadDataValid), 64'd1);
                    check({tag, "_hold_data"}, LoadData, exp);
                    step();
                end
                LoadDataReady = 1'b1;
            end
            check({tag, "_valid"}, 64'(LoadDataValid), 64'd1);
            check({tag, "_data"}, LoadData, exp);
            step();
        end
        check({tag, "_done"}, 64'(LoadDataValid), 64'd0);
        check({tag, "_idle"}, 64'(CmdOutReady), 64'd1);
    endtask

    initial begin
        Reset          = 1'b0;
        CmdOutValid    = 1'b0;
        CmdOut         = CmdUpdate;
        AddrOut        = '0;
        OldLeaf        = '0;
        NewLeaf        = '0;
        StoreDataValid = 1'b0;
        StoreData      = '0;
        LoadDataReady  = 1'b1;
        repeat (3) step();

        check("rst_cmdrdy", 64'(CmdOutReady), 64'd0);
        check("rst_strdy", 64'(StoreDataReady), 64'd0);
        check("rst_ldval", 64'(LoadDataValid), 64'd0);
        check("rst_lddata", LoadData, 64'd0);
        check("rst_adderr", 64'(AddrError), 64'd0);
        check("rst_leferr", 64'(LeafError), 64'd0);
        Reset = 1'b1;
        step();
        check("post_rst_cmdrdy", 64'(CmdOutReady), 64'd1);

        sendCmd(CmdAppend, 32'd5, 10'h0, 10'h12);
        check("store_cmdrdy_low", 64'(CmdOutReady), 64'd0);
        storeBlock(64'h0, BlkChunks);
        check("append_done_cmdrdy", 64'(CmdOutReady), 64'd1);

        sendCmd(CmdRead, 32'd5, 10'h12, 10'h12);
        check("load_cmdrdy_low", 64'(CmdOutReady), 64'd0);
        recvBlock("rd5", 64'h0, 1'b0, -1);
        check("rd5_leaferr", 64'(LeafError), 64'd0);

        sendCmd(CmdRead, 32'd9, 10'h3, 10'h4);
        recvBlock("rd9", 64'h0, 1'b1, -1);
        check("rd9_adderr", 64'(AddrError), 64'd0);
        check("rd9_leaferr", 64'(LeafError), 64'd0);

        sendCmd(CmdReadRmv, 32'd5, 10'h12, 10'h0);
        recvBlock("rmv5", 64'h0, 1'b0, -1);
        sendCmd(CmdRead, 32'd5, 10'h12, 10'h12);
        recvBlock("rd5_gone", 64'h0, 1'b1, -1);

        sendCmd(CmdAppend, 32'd5, 10'h0, 10'h12);
        storeBlock(64'h10, BlkChunks);
        sendCmd(CmdRead, 32'd5, 10'h12, 10'h12);
        recvBlock("stall", 64'h10, 1'b0, 1);
        check("stall_leaferr", 64'(LeafError), 64'd0);

        sendCmd(CmdUpdate, 32'd5, 10'h13, 10'h14);
        check("upd_leaferr", 64'(LeafError), 64'(LeafOn));
        storeBlock(64'h20, BlkChunks);
        sendCmd(CmdRead, 32'd5, 10'h14, 10'h14);
        recvBlock("rd_upd", 64'h20, 1'b0, -1);
        check("leaferr_sticky", 64'(LeafError), 64'(LeafOn));
        check("upd_adderr", 64'(AddrError), 64'd0);

        sendCmd(CmdRead, 32'd300, 10'h0, 10'h0);
        check("oob_adderr", 64'(AddrError), 64'd1);
        recvBlock("rd300", 64'h0, 1'b1, -1);

        sendCmd(CmdAppend, 32'd7, 10'h0, 10'h5);
        storeBlock(64'h70, 3);
        Reset = 1'b0;
        #1;
        check("midrst_cmdrdy", 64'(CmdOutReady), 64'd0);
        check("midrst_strdy", 64'(StoreDataReady), 64'd0);
        check("midrst_adderr", 64'(AddrError), 64'd0);
        check("midrst_leferr", 64'(LeafError), 64'd0);
        step();
        Reset = 1'b1;
        step();
        sendCmd(CmdRead, 32'd7, 10'h5, 10'h5);
        recvBlock("rd7", 64'h0, 1'b1, -1);
        check("rd7_adderr", 64'(AddrError), 64'd0);
        check("rd7_leferr", 64'(LeafError), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
